elgamal_encryptor_seq: RTL and testbench
========================================

Name: elgamal_encryptor_seq

Overview:
Parametrised, sequential ElGamal encryption engine. Accepts one job (p, g, y, k, m) and produces the cryptogram pair c1 = g^k mod p and c2 = m·y^k mod p on two AXI-Stream-style outputs. It adds width parametrisation, input ready/backpressure, a constant-time exponentiation schedule and input validation. It sits between the key/message sources and the transmit path, alongside the decrypting entity.

Parameters:
WIDTH, 64, bit width of p, g, y, k, m and outputs (min 4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
input_p_tdata  in  WIDTH  modulus p
input_g_tdata  in  WIDTH  generator g
input_y_tdata  in  WIDTH  recipient public key y = g^x mod p
input_k_tdata  in  WIDTH  ephemeral exponent k
input_m_tdata  in  WIDTH  message m
input_tvalid  in  1  all five input fields valid
input_tready  out  1  engine idle, job accepted on tvalid&tready
output_a_tdata  out  WIDTH  c1
output_a_tvalid  out  1  c1 valid
output_a_tready  in  1  sink ready for c1
output_b_tdata  out  WIDTH  c2
output_b_tvalid  out  1  c2 valid
output_b_tready  in  1  sink ready for c2
output_err  out  1  job rejected; qualified by either output tvalid

Behaviour:
- Reset: input_tready=0 during rst, 1 in the first cycle after rst deasserts. All tvalid=0, all tdata=0, output_err=0, FSM=IDLE.
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- FSM states: IDLE, CHECK, SQ_A, SQ_B, MUL_A, MUL_B, FINAL, OUT.
- IDLE: input_tready=1. A handshake registers all fields; the next state is CHECK.
- CHECK (1 cycle): reject if p<3, p even, g>=p, y>=p, m>=p, or k==0. Reject path: both outputs tdata=0, output_err=1, go to OUT. Otherwise set ra=1, rb=1, bit index i=WIDTH-1, go to SQ_A.
- Per bit of k, MSB first, always all four multiplies (constant time, independent of k value):
  - ra=ra·ra mod p, then rb=rb·rb mod p.
  - ta=ra·g mod p, then tb=rb·y mod p.
  - If k[i]=1 then ra=ta, rb=tb; otherwise unchanged.
- After i=0: FINAL computes rb=m·rb mod p. c1=ra, c2=rb, err=0, go to OUT.
- Each multiply occupies exactly WIDTH+1 cycles (1 launch + WIDTH iterations).
- Latency from accept to both tvalid high: L=(4·WIDTH+1)·(WIDTH+1)+2 cycles. Reject latency is 2 cycles.
- OUT: output_a_tvalid and output_b_tvalid rise together. Each drops independently on its own tvalid&tready. tdata and err stay stable while tvalid=1.
- Return to IDLE in the cycle after both outputs have been accepted. A same-cycle dual accept also returns next cycle.
- input_tready=0 in every state except IDLE. Input changes while busy are ignored.
- Arithmetic: operands < p. Intermediates are WIDTH+1 bits. Reduction is by a single conditional subtract per step; no division.
- rst mid-computation or mid-OUT: abort immediately to reset values. A pending output is discarded.

Decomposition:
- Package elgamal_pkg: FSM state enum, MUL_CYCLES=WIDTH+1 function, latency function L(WIDTH).
- Sub-module mod_mul_serial (WIDTH):
  - Interleaved double-and-add computing a·b mod p, MSB of b first.
  - Ports: clk, rst, start, a, b, p, result, done.
  - done pulses exactly WIDTH cycles after start.
  - Verified standalone against a reference model.

Test Plan:
- WIDTH=8, p=23, g=5, y=8, k=3, m=10, both treadys=1 -> c1=10, c2=14, err=0; tvalid at exactly 299 cycles after accept; input_tready=0 throughout.
- WIDTH=8, p=23, g=5, y=8, k=1, m=10 -> c1=5, c2=11. Then k=255 -> c1=21, c2=19. Latency identical (299) for all three k values.
- Validation: m=23, then p=22, then k=0 (other fields from the first case) -> each yields both tdata=0, err=1, 2-cycle latency; the next valid job then completes correctly.
- Backpressure: output_a_tready=1, output_b_tready=0 for 10 cycles -> c1 accepted at once; c2=14 held stable; input_tready stays 0 until the cycle after c2 is accepted.
- Reset mid-job: assert rst 100 cycles after accept -> all outputs 0 next cycle, no tvalid; a fresh job returns correct c1=10, c2=14.
- WIDTH=64 random regression: 200 random primes p<2^64 with random g, y, m<p and k -> matches the software pow-mod model; latency 257·65+2=16707.

Source files
------------

// File: rtl/elgamal_pkg.sv
// Shared types and timing helpers for the sequential ElGamal encryptor.
package elgamal_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SQ_A  = 3'd2,
    S_SQ_B  = 3'd3,
    S_MUL_A = 3'd4,
    S_MUL_B = 3'd5,
    S_FINAL = 3'd6,
    S_OUT   = 3'd7
  } state_t;

  // Cycles spent in one modular multiply state: one launch cycle plus WIDTH iterations.
  function automatic int mul_cycles(input int width);
    return width + 32'sd1;
  endfunction

  // Cycles from the input handshake cycle to the cycle in which both outputs are valid.
  function automatic int latency(input int width);
    return (32'sd4 * width + 32'sd1) * mul_cycles(width) + 32'sd2;
  endfunction

endpackage

// File: rtl/elgamal_encryptor_seq_mod_mul.sv
// Bit-serial interleaved double-and-add modular multiplier (a*b mod p, MSB of b first).
// The first iteration is folded into the launch edge so that done is high exactly
// WIDTH cycles after start; result is valid while done is high and until the next start.
module mod_mul_serial #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;

  // One double-and-add step; operands are < p so each reduction needs one subtract.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] aa,
                                                input logic [WIDTH-1:0] pp,
                                                input logic             bit_in);
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] sum;
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, pp}) begin
      dbl = dbl - {1'b0, pp};
    end else begin
      dbl = dbl;
    end
    sum = dbl + (bit_in ? {1'b0, aa} : {(WIDTH + 1){1'b0}});
    if (sum >= {1'b0, pp}) begin
      sum = sum - {1'b0, pp};
    end else begin
      sum = sum;
    end
    return sum[WIDTH-1:0];
  endfunction

  // Launch on start (first bit processed immediately), then one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= '0;
      a_r    <= '0;
      p_r    <= '0;
      b_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      acc_r  <= mod_step({WIDTH{1'b0}}, a, p, b[WIDTH-1]);
      a_r    <= a;
      p_r    <= p;
      b_r    <= {b[WIDTH-2:0], 1'b0};
      cnt_r  <= CW'(WIDTH - 1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      acc_r <= mod_step(acc_r, a_r, p_r, b_r[WIDTH-1]);
      b_r   <= {b_r[WIDTH-2:0], 1'b0};
      cnt_r <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign result = acc_r;
  assign done   = done_r;

endmodule

// File: rtl/elgamal_encryptor_seq.sv
// Sequential ElGamal encryptor: c1 = g^k mod p, c2 = m*y^k mod p.
// Exponentiation runs a fixed square/square/multiply/multiply schedule per bit of k
// so the run time does not depend on the value of k.
module elgamal_encryptor_seq
  import elgamal_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_p_tdata,
  input  logic [WIDTH-1:0] input_g_tdata,
  input  logic [WIDTH-1:0] input_y_tdata,
  input  logic [WIDTH-1:0] input_k_tdata,
  input  logic [WIDTH-1:0] input_m_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic [WIDTH-1:0] output_a_tdata,
  output logic             output_a_tvalid,
  input  logic             output_a_tready,
  output logic [WIDTH-1:0] output_b_tdata,
  output logic             output_b_tvalid,
  input  logic             output_b_tready,
  output logic             output_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  state_t           state_r;
  logic [WIDTH-1:0] p_r, g_r, y_r, k_r, m_r;
  logic [WIDTH-1:0] ra_r, rb_r, ta_r;
  logic [IW-1:0]    bit_r;
  logic             mul_start_r;
  logic             input_tready_r;
  logic [WIDTH-1:0] a_tdata_r, b_tdata_r;
  logic             a_tvalid_r, b_tvalid_r, err_r;

  logic [WIDTH-1:0] mul_a_s, mul_b_s, mul_result_s;
  logic             mul_done_s;
  logic             reject_s;

  // Input validation of the captured job.
  always_comb begin
    reject_s = (p_r < THREE) || !p_r[0] || (g_r >= p_r) || (y_r >= p_r) ||
               (m_r >= p_r) || (k_r == {WIDTH{1'b0}});
  end

  // Multiplier operand selection per schedule step.
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    case (state_r)
      S_SQ_A:  begin mul_a_s = ra_r; mul_b_s = ra_r; end
      S_SQ_B:  begin mul_a_s = rb_r; mul_b_s = rb_r; end
      S_MUL_A: begin mul_a_s = ra_r; mul_b_s = g_r;  end
      S_MUL_B: begin mul_a_s = rb_r; mul_b_s = y_r;  end
      S_FINAL: begin mul_a_s = m_r;  mul_b_s = rb_r; end
      default: begin mul_a_s = '0;   mul_b_s = '0;   end
    endcase
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_r),
    .a      (mul_a_s),
    .b      (mul_b_s),
    .p      (p_r),
    .result (mul_result_s),
    .done   (mul_done_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      p_r            <= '0;
      g_r            <= '0;
      y_r            <= '0;
      k_r            <= '0;
      m_r            <= '0;
      ra_r           <= '0;
      rb_r           <= '0;
      ta_r           <= '0;
      bit_r          <= '0;
      mul_start_r    <= 1'b0;
      input_tready_r <= 1'b0;
      a_tdata_r      <= '0;
      b_tdata_r      <= '0;
      a_tvalid_r     <= 1'b0;
      b_tvalid_r     <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      mul_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (input_tvalid && input_tready_r) begin
            p_r            <= input_p_tdata;
            g_r            <= input_g_tdata;
            y_r            <= input_y_tdata;
            k_r            <= input_k_tdata;
            m_r            <= input_m_tdata;
            input_tready_r <= 1'b0;
            state_r        <= S_CHECK;
          end else begin
            input_tready_r <= 1'b1;
          end
        end
        S_CHECK: begin
          if (reject_s) begin
            a_tdata_r  <= '0;
            b_tdata_r  <= '0;
            err_r      <= 1'b1;
            a_tvalid_r <= 1'b1;
            b_tvalid_r <= 1'b1;
            state_r    <= S_OUT;
          end else begin
            ra_r        <= ONE;
            rb_r        <= ONE;
            bit_r       <= IW'(WIDTH - 1);
            mul_start_r <= 1'b1;
            state_r     <= S_SQ_A;
          end
        end
        S_SQ_A: begin
          if (mul_done_s) begin
            ra_r        <= mul_result_s;
            mul_start_r <= 1'b1;
            state_r     <= S_SQ_B;
          end else begin
            state_r <= S_SQ_A;
          end
        end
        S_SQ_B: begin
          if (mul_done_s) begin
            rb_r        <= mul_result_s;
            mul_start_r <= 1'b1;
            state_r     <= S_MUL_A;
          end else begin
            state_r <= S_SQ_B;
          end
        end
        S_MUL_A: begin
          if (mul_done_s) begin
            ta_r        <= mul_result_s;
            mul_start_r <= 1'b1;
            state_r     <= S_MUL_B;
          end else begin
            state_r <= S_MUL_A;
          end
        end
        S_MUL_B: begin
          if (mul_done_s) begin
            // Both products are always computed; k only selects which are kept.
            if (k_r[bit_r]) begin
              ra_r <= ta_r;
              rb_r <= mul_result_s;
            end else begin
              ra_r <= ra_r;
              rb_r <= rb_r;
            end
            mul_start_r <= 1'b1;
            if (bit_r == IW'(0)) begin
              state_r <= S_FINAL;
            end else begin
              bit_r   <= bit_r - IW'(1);
              state_r <= S_SQ_A;
            end
          end else begin
            state_r <= S_MUL_B;
          end
        end
        S_FINAL: begin
          if (mul_done_s) begin
            a_tdata_r  <= ra_r;
            b_tdata_r  <= mul_result_s;
            err_r      <= 1'b0;
            a_tvalid_r <= 1'b1;
            b_tvalid_r <= 1'b1;
            state_r    <= S_OUT;
          end else begin
            state_r <= S_FINAL;
          end
        end
        S_OUT: begin
          if (a_tvalid_r && output_a_tready) begin
            a_tvalid_r <= 1'b0;
          end else begin
            a_tvalid_r <= a_tvalid_r;
          end
          if (b_tvalid_r && output_b_tready) begin
            b_tvalid_r <= 1'b0;
          end else begin
            b_tvalid_r <= b_tvalid_r;
          end
          if (!(a_tvalid_r && !output_a_tready) && !(b_tvalid_r && !output_b_tready)) begin
            input_tready_r <= 1'b1;
            state_r        <= S_IDLE;
          end else begin
            state_r <= S_OUT;
          end
        end
        default: begin
          input_tready_r <= 1'b0;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

  assign input_tready    = input_tready_r;
  assign output_a_tdata  = a_tdata_r;
  assign output_a_tvalid = a_tvalid_r;
  assign output_b_tdata  = b_tdata_r;
  assign output_b_tvalid = b_tvalid_r;
  assign output_err      = err_r;

endmodule

// File: tb/tb_elgamal_encryptor_seq.sv
// Directed bench for elgamal_encryptor_seq at WIDTH=8.
module tb_elgamal_encryptor_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_p = 8'd0, in_g = 8'd0, in_y = 8'd0, in_k = 8'd0, in_m = 8'd0;
  logic       in_tvalid = 1'b0;
  logic       in_tready;
  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, b_tvalid, err;
  logic       a_tready = 1'b1;
  logic       b_tready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  elgamal_encryptor_seq #(.WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .input_p_tdata   (in_p),
    .input_g_tdata   (in_g),
    .input_y_tdata   (in_y),
    .input_k_tdata   (in_k),
    .input_m_tdata   (in_m),
    .input_tvalid    (in_tvalid),
    .input_tready    (in_tready),
    .output_a_tdata  (a_tdata),
    .output_a_tvalid (a_tvalid),
    .output_a_tready (a_tready),
    .output_b_tdata  (b_tdata),
    .output_b_tvalid (b_tvalid),
    .output_b_tready (b_tready),
    .output_err      (err)
  );

  always #5 clk = ~clk;

  // Reference modular exponentiation by repeated multiplication.
  function automatic int powmod(input int b, input int e, input int p);
    int r;
    r = 1 % p;
    for (int i = 0; i < e; i++) r = (r * b) % p;
    return r;
  endfunction

  // Submit one job and wait (bounded) for the outputs; lat = cycles from handshake cycle.
  task automatic run_job(input logic [7:0] p, g, y, k, m,
                         output logic [7:0] c1, output logic [7:0] c2, output logic e,
                         output int lat, output logic rdy_seen);
    int w;
    w = 0;
    while (in_tready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    in_p = p; in_g = g; in_y = y; in_k = k; in_m = m;
    in_tvalid = 1'b1;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    in_p = 8'hFF; in_g = 8'hFF; in_y = 8'hFF; in_k = 8'hFF; in_m = 8'hFF;
    lat = 1;
    rdy_seen = 1'b0;
    while (a_tvalid !== 1'b1 && lat < 2000) begin
      if (in_tready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (lat >= 2000) lat = -1;
    c1 = a_tdata; c2 = b_tdata; e = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", in_tready); end
    n_checks++; if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b%b expected 00", a_tvalid, b_tvalid); end
    n_checks++; if (a_tdata !== 8'd0 || b_tdata !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %0d %0d %b expected 0 0 0", a_tdata, b_tdata, err); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b expected 1", in_tready); end
  endtask

  task automatic test_basic();
    logic [7:0] c1, c2; logic e, rs; int lat;
    run_job(8'd23, 8'd5, 8'd8, 8'd3, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd10) begin n_fail++; $display("FAIL basic_c1: got %0d expected 10", c1); end
    n_checks++; if (c2 !== 8'd14) begin n_fail++; $display("FAIL basic_c2: got %0d expected 14", c2); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", e); end
    n_checks++; if (b_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_b_tvalid: got %b expected 1", b_tvalid); end
    n_checks++; if (lat !== 299) begin n_fail++; $display("FAIL basic_latency: got %0d expected 299", lat); end
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL basic_busy_tready: got %b expected 0", rs); end
  endtask

  task automatic test_k_values();
    logic [7:0] c1, c2; logic e, rs; int lat;
    run_job(8'd23, 8'd5, 8'd8, 8'd1, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd5 || c2 !== 8'd11) begin n_fail++; $display("FAIL k1_result: got %0d %0d expected 5 11", c1, c2); end
    n_checks++; if (lat !== 299) begin n_fail++; $display("FAIL k1_latency: got %0d expected 299", lat); end
    run_job(8'd23, 8'd5, 8'd8, 8'd255, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd21 || c2 !== 8'd19) begin n_fail++; $display("FAIL k255_result: got %0d %0d expected 21 19", c1, c2); end
    n_checks++; if (lat !== 299) begin n_fail++; $display("FAIL k255_latency: got %0d expected 299", lat); end
  endtask

  task automatic test_validation();
    logic [7:0] c1, c2; logic e, rs; int lat;
    logic [7:0] vp [3];
    logic [7:0] vk [3];
    logic [7:0] vm [3];
    vp[0] = 8'd23; vk[0] = 8'd3; vm[0] = 8'd23;
    vp[1] = 8'd22; vk[1] = 8'd3; vm[1] = 8'd10;
    vp[2] = 8'd23; vk[2] = 8'd0; vm[2] = 8'd10;
    for (int i = 0; i < 3; i++) begin
      run_job(vp[i], 8'd5, 8'd8, vk[i], vm[i], c1, c2, e, lat, rs);
      n_checks++; if (c1 !== 8'd0 || c2 !== 8'd0 || e !== 1'b1) begin n_fail++; $display("FAIL reject%0d_out: got %0d %0d err=%b expected 0 0 err=1", i, c1, c2, e); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL reject%0d_latency: got %0d expected 2", i, lat); end
    end
    run_job(8'd23, 8'd5, 8'd8, 8'd3, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd10 || c2 !== 8'd14 || e !== 1'b0) begin n_fail++; $display("FAIL after_reject: got %0d %0d err=%b expected 10 14 err=0", c1, c2, e); end
  endtask

  task automatic test_backpressure();
    logic [7:0] c1, c2; logic e, rs; int lat;
    a_tready = 1'b1; b_tready = 1'b0;
    run_job(8'd23, 8'd5, 8'd8, 8'd3, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd10 || c2 !== 8'd14) begin n_fail++; $display("FAIL bp_result: got %0d %0d expected 10 14", c1, c2); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_tvalid !== 1'b0 || b_tvalid !== 1'b1 || b_tdata !== 8'd14 || in_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got a_v=%b b_v=%b b=%0d rdy=%b expected 0 1 14 0", i, a_tvalid, b_tvalid, b_tdata, in_tready);
      end
    end
    b_tready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (b_tvalid !== 1'b0 || in_tready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got b_v=%b rdy=%b expected 0 1", b_tvalid, in_tready); end
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] c1, c2; logic e, rs; int lat;
    int w;
    w = 0;
    while (in_tready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    in_p = 8'd23; in_g = 8'd5; in_y = 8'd8; in_k = 8'd3; in_m = 8'd10;
    in_tvalid = 1'b1;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0 || a_tdata !== 8'd0 || b_tdata !== 8'd0 || err !== 1'b0 || in_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b%b a=%0d b=%0d err=%b rdy=%b expected all 0", a_tvalid, b_tvalid, a_tdata, b_tdata, err, in_tready);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_output: got %b%b expected 00", a_tvalid, b_tvalid); end
    run_job(8'd23, 8'd5, 8'd8, 8'd3, 8'd10, c1, c2, e, lat, rs);
    n_checks++; if (c1 !== 8'd10 || c2 !== 8'd14 || lat !== 299) begin n_fail++; $display("FAIL midreset_fresh: got %0d %0d lat=%0d expected 10 14 lat=299", c1, c2, lat); end
  endtask

  task automatic test_random();
    logic [7:0] c1, c2; logic e, rs; int lat;
    int primes [5];
    int p, g, y, k, m, x1, x2;
    primes[0] = 251; primes[1] = 241; primes[2] = 197; primes[3] = 131; primes[4] = 7;
    for (int i = 0; i < 8; i++) begin
      p = primes[$urandom_range(0, 4)];
      g = $urandom_range(0, p - 1);
      y = $urandom_range(0, p - 1);
      m = $urandom_range(0, p - 1);
      k = $urandom_range(1, 255);
      x1 = powmod(g, k, p);
      x2 = (m * powmod(y, k, p)) % p;
      run_job(8'(p), 8'(g), 8'(y), 8'(k), 8'(m), c1, c2, e, lat, rs);
      n_checks++;
      if (c1 !== 8'(x1) || c2 !== 8'(x2) || e !== 1'b0 || lat !== 299) begin
        n_fail++;
        $display("FAIL random%0d p=%0d g=%0d y=%0d k=%0d m=%0d: got %0d %0d err=%b lat=%0d expected %0d %0d err=0 lat=299",
                 i, p, g, y, k, m, c1, c2, e, lat, x1, x2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k_values();
    test_validation();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
